// File: rtl/gsensor_axis_filter.sv
// Accelerometer axis smoother: re-times the slow SPI-held value, accepts it at a
// fixed rate once stable, and publishes a power-of-two moving average.
module gsensor_axis_filter #(
  parameter int SAMPLE_DIV    = 50000,
  parameter int STABLE_CYCLES = 8,
  parameter int LOG2_DEPTH    = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [15:0] iDATA,
  input  logic        iEN,
  output logic [15:0] oDATA,
  output logic        oVALID,
  output logic        oFULL
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = 16 + LOG2_DEPTH;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int FILL_W = LOG2_DEPTH + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [15:0]             sync_meta;
  logic [15:0]             sync;
  logic [7:0]              stable_cnt;
  logic                    stable;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic                    pending;
  logic                    accept;
  logic [1:0]              state;
  logic [15:0]             smp;
  logic [15:0]             ring [DEPTH];
  logic [15:0]             old_smp;
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [FILL_W-1:0]       fill_cnt;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] smp_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic [15:0]             avg;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      // NOTE: non-blocking assignments make this a true two-flop chain; blocking ones would collapse it.
      sync_meta <= iDATA;
      sync      <= sync_meta;
    end
  end

  // The counter clears on the same edge that sync takes a new value.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stable_cnt <= '0;
    end else if (sync_meta != sync) begin
      stable_cnt <= '0;
    end else if (stable_cnt != 8'(STABLE_CYCLES)) begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

  assign stable = (stable_cnt == 8'(STABLE_CYCLES));
  assign tick   = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign accept = (state == S_WAIT) && stable;

  // Ticks landing while a request is outstanding simply merge into it.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_cnt <= '0;
      pending <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick)        pending <= 1'b1;
      else if (accept) pending <= 1'b0;
    end
  end

  assign old_smp = ring[wr_ptr];
  assign smp_ext = {{LOG2_DEPTH{smp[15]}}, smp};
  assign old_ext = {{LOG2_DEPTH{old_smp[15]}}, old_smp};
  // Top 16 bits of the sum are the floor of an arithmetic divide by the depth.
  assign avg     = sum[LOG2_DEPTH +: 16];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= S_IDLE;
      smp      <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      sum      <= '0;
      oDATA    <= '0;
      oVALID   <= 1'b0;
      oFULL    <= 1'b0;
      // NOTE: the window is a small register file that must start at zero, so every entry is reset.
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      oVALID <= 1'b0;
      case (state)
        S_IDLE: if (pending) state <= S_WAIT;
        S_WAIT: begin
          if (stable) begin
            smp   <= sync;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          sum          <= sum + smp_ext - old_ext;
          ring[wr_ptr] <= smp;
          wr_ptr       <= wr_ptr + LOG2_DEPTH'(1);
          if (fill_cnt != FILL_W'(DEPTH))   fill_cnt <= fill_cnt + FILL_W'(1);
          if (fill_cnt == FILL_W'(DEPTH-1)) oFULL    <= 1'b1;
          state <= S_OUT;
        end
        S_OUT: begin
          oDATA  <= iEN ? avg : smp;
          oVALID <= 1'b1;
          state  <= pending ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsensor_axis_filter.sv
// Scoreboard bench for gsensor_axis_filter: stimulus queues hand-computed
// strobe values, a monitor pops and compares on every oVALID.
module tb_gsensor_axis_filter;

  localparam int SAMPLE_DIV    = 16;
  localparam int STABLE_CYCLES = 4;
  localparam int LOG2_DEPTH    = 3;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [15:0] iDATA = 16'h0000;
  logic        iEN = 1'b1;
  logic [15:0] oDATA;
  logic        oVALID;
  logic        oFULL;

  typedef struct packed {
    logic [15:0] data;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = 0;
  int   rel_cyc = 0;

  gsensor_axis_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iDATA(iDATA),
    .iEN(iEN),
    .oDATA(oDATA),
    .oVALID(oVALID),
    .oFULL(oFULL)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_strobe(input logic [15:0] d, input logic f);
    exp_t e;
    e.data = d;
    e.full = f;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge iCLK) begin
    exp_t e;
    if (!iRST && oVALID) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got oDATA=0x%0h, expected no strobe", oDATA);
      end else begin
        e = exp_q.pop_front();
        check("strobe_data", 32'(oDATA), 32'(e.data));
        check("strobe_full", 32'(oFULL), 32'(e.full));
      end
    end
  end

  task automatic check_reset_outputs();
    check("reset_oDATA", 32'(oDATA), 32'h0);
    check("reset_oVALID", 32'(oVALID), 32'h0);
    check("reset_oFULL", 32'(oFULL), 32'h0);
  endtask

  task automatic do_reset(input logic [15:0] d, input logic en);
    @(negedge iCLK);
    iRST  = 1'b1;
    iDATA = d;
    iEN   = en;
    exp_q.delete();
    repeat (5) @(negedge iCLK);
    check_reset_outputs();
    iRST    = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int start = strobe_cnt;
    int k = 0;
    while (strobe_cnt < start + n && k < budget) begin
      @(negedge iCLK);
      k++;
    end
    if (strobe_cnt < start + n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d strobes, expected %0d", name, strobe_cnt - start, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int last_change;
    int k;

    // Reset state, then first sample latency and value.
    do_reset(16'h1234, 1'b1);
    expect_strobe(16'h0246, 1'b0);
    wait_strobes(1, 40, "first_sample");
    check_range("first_strobe_latency", last_strobe_cyc - rel_cyc, 18, 21);

    // Fill with a constant: average ramps, oFULL rises on the 8th strobe.
    do_reset(16'h0100, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      expect_strobe(16'((i < 8 ? i : 8) * 32), i >= 8);
      wait_strobes(1, 40, "fill");
    end

    // Negative values round toward minus infinity.
    do_reset(16'hFFF8, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      expect_strobe(16'(-i), i >= 8);
      wait_strobes(1, 40, "negative");
    end

    // Bus toggling faster than the stability window blocks all sampling.
    do_reset(16'h0001, 1'b1);
    base = strobe_cnt;
    for (int i = 0; i < 33; i++) begin
      repeat (3) @(negedge iCLK);
      iDATA = iDATA ^ 16'h0003;
    end
    last_change = cyc;
    check("no_strobe_while_toggling", 32'(strobe_cnt - base), 32'd0);
    expect_strobe(16'h0000, 1'b0);
    repeat (11) @(negedge iCLK);
    check("single_strobe_after_settle", 32'(strobe_cnt - base), 32'd1);
    check_range("settle_latency", last_strobe_cyc - last_change, 8, 10);

    // Bypass shows the raw sample; re-enable gives the wrapped window average.
    do_reset(16'h0010, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      expect_strobe(16'(2 * i), i >= 8);
      wait_strobes(1, 40, "bypass_fill");
    end
    iEN   = 1'b0;
    iDATA = 16'h0090;
    expect_strobe(16'h0090, 1'b1);
    wait_strobes(1, 40, "bypass");
    iEN = 1'b1;
    expect_strobe(16'h0030, 1'b1);
    wait_strobes(1, 40, "reenable");

    // Reset while the window is being updated discards that sample.
    do_reset(16'h0100, 1'b1);
    expect_strobe(16'h0020, 1'b0);
    wait_strobes(1, 40, "midreset_pre1");
    expect_strobe(16'h0040, 1'b0);
    wait_strobes(1, 40, "midreset_pre2");
    k = 0;
    while (dut.state != 2'd2 && k < 40) begin
      @(negedge iCLK);
      k++;
    end
    check("reached_update_state", 32'(dut.state), 32'd2);
    iRST = 1'b1;
    base = strobe_cnt;
    repeat (3) @(negedge iCLK);
    check_reset_outputs();
    iDATA   = 16'h0200;
    iRST    = 1'b0;
    rel_cyc = cyc;
    expect_strobe(16'h0040, 1'b0);
    wait_strobes(1, 40, "after_midreset");
    check("no_strobe_for_discarded", 32'(strobe_cnt - base), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
